// File: rtl/cosim_trace_pkg.sv
`default_nettype none
// ============================================================================
// cosim_trace_pkg - shared record type, trace type codes and beat states
// Revision: 1.0
// ============================================================================
package cosim_trace_pkg;

    localparam logic [7:0] TRACE_COMMIT = 8'hC0;
    localparam logic [7:0] TRACE_EXCEP  = 8'hE0;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PC   = 2'd1,
        S_INS  = 2'd2,
        S_DATA = 2'd3
    } beat_state_t;

    typedef struct packed {
        logic wr_valid;
        logic compressed;
        logic excep;
    } trace_flags_t;

    typedef struct packed {
        logic [63:0]  pc;
        logic [31:0]  instr;
        logic [4:0]   dest;
        trace_flags_t flags;
        logic [63:0]  data;
        logic [15:0]  seq;
        logic [7:0]   drop_cnt;
    } trace_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// commit_trace_fifo - first-word fall-through FIFO of trace records
// Revision: 1.0
// ============================================================================
module commit_trace_fifo
    import cosim_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  trace_rec_t             din,
    input  logic                   pop,
    output trace_rec_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int C_AW = $clog2(DEPTH);

    trace_rec_t       r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;

    // A push into a full FIFO lands in the slot being popped this same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (C_AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/commit_trace_tx.sv
`default_nettype none
// ============================================================================
// commit_trace_tx - captures retired ops and streams them as 4-beat records
// Revision: 1.0
// ============================================================================
module commit_trace_tx
    import cosim_trace_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [63:0] START_PC   = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic        stall_exe,
    input  logic [63:0] pc,
    input  logic [31:0] instr,
    input  logic [4:0]  xreg_dest,
    input  logic        xreg_we,
    input  logic [63:0] commit_data,
    input  logic        excep,
    input  logic [63:0] excep_cause,
    input  logic [63:0] hart_id,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [63:0] trace_data,
    output logic        trace_last,
    output logic        armed,
    output logic        overflow
);

    beat_state_t r_state;
    logic        r_armed;
    logic        r_overflow;
    logic [15:0] r_seq;
    logic [7:0]  r_drop_cnt;

    logic        w_capture;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    trace_rec_t  w_rec;
    trace_rec_t  w_head;
    logic [$clog2(FIFO_DEPTH):0] w_unused_count;
    logic        unused_hart_bits;

    assign w_capture = commit && !stall_exe && (r_armed || pc == START_PC);
    // S_DATA is only reachable with a record at the head, so no empty check.
    assign w_pop     = (r_state == S_DATA) && trace_ready;
    assign w_push    = w_capture && (!w_full || w_pop);

    always_comb begin
        w_rec                  = '0;
        w_rec.pc               = pc;
        w_rec.instr            = instr;
        w_rec.dest             = xreg_dest;
        w_rec.flags.wr_valid   = xreg_we && (xreg_dest != 5'd0);
        w_rec.flags.compressed = (instr[1:0] != 2'b11);
        w_rec.flags.excep      = excep;
        w_rec.data             = excep ? excep_cause : commit_data;
        w_rec.seq              = r_seq;
        w_rec.drop_cnt         = r_drop_cnt;
    end

    commit_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_rec),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_unused_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
            r_seq      <= 16'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_capture) begin
                r_armed <= 1'b1;
                r_seq   <= r_seq + 16'd1;
            end
            if (w_push) begin
                r_drop_cnt <= 8'd0;
            end else if (w_capture) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            if (trace_valid && trace_ready) begin
                case (r_state)
                    S_HDR:   r_state <= S_PC;
                    S_PC:    r_state <= S_INS;
                    S_INS:   r_state <= S_DATA;
                    default: r_state <= S_HDR;
                endcase
            end
        end
    end

    assign trace_valid = (r_state == S_HDR) ? !w_empty : 1'b1;
    assign trace_last  = (r_state == S_DATA);

    always_comb begin
        trace_data = 64'd0;
        case (r_state)
            S_HDR: begin
                if (!w_empty) begin
                    trace_data = {hart_id[7:0],
                                  w_head.flags.excep ? TRACE_EXCEP : TRACE_COMMIT,
                                  w_head.seq, w_head.dest,
                                  w_head.flags.wr_valid, w_head.flags.compressed,
                                  w_head.flags.excep, w_head.drop_cnt, 16'h0000};
                end
            end
            S_PC:    trace_data = w_head.pc;
            S_INS:   trace_data = {32'h0, w_head.instr};
            default: trace_data = w_head.data;
        endcase
    end

    assign armed            = r_armed;
    assign overflow         = r_overflow;
    assign unused_hart_bits = ^hart_id[63:8];

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_tx.sv
`default_nettype none
// ============================================================================
// tb_commit_trace_tx - directed table, overflow/reset sequences, random vs model
// Revision: 1.0
// ============================================================================
module tb_commit_trace_tx;

    localparam int          FIFO_DEPTH = 16;
    localparam logic [63:0] START_PC   = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit, stall_exe, xreg_we, excep, trace_ready;
    logic [63:0] pc, commit_data, excep_cause, hart_id;
    logic [31:0] instr;
    logic [4:0]  xreg_dest;
    logic        trace_valid, trace_last, armed, overflow;
    logic [63:0] trace_data;

    commit_trace_tx #(.FIFO_DEPTH(FIFO_DEPTH), .START_PC(START_PC)) dut (
        .clk(clk), .rst(rst), .commit(commit), .stall_exe(stall_exe), .pc(pc),
        .instr(instr), .xreg_dest(xreg_dest), .xreg_we(xreg_we),
        .commit_data(commit_data), .excep(excep), .excep_cause(excep_cause),
        .hart_id(hart_id), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_last(trace_last), .armed(armed),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    typedef logic [3:0][63:0] rec_t;
    rec_t        mq[$];
    logic [63:0] obs[$];
    int          bi;
    logic        m_armed, m_ovf;
    logic [15:0] m_seq;
    logic [7:0]  m_drop;
    logic        exp_v, m_full, m_pop;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        we;
        logic [63:0] data;
        logic        exc;
        logic [63:0] cause;
        logic [63:0] hdr;
        logic [63:0] b3;
    } vec_t;
    vec_t vec[5];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic rec_t make_rec(logic [15:0] s, logic [7:0] d);
        rec_t r;
        r[0] = {hart_id[7:0], excep ? 8'hE0 : 8'hC0, s, xreg_dest,
                xreg_we && (xreg_dest != 5'd0), instr[1:0] != 2'b11, excep, d, 16'h0};
        r[1] = pc;
        r[2] = {32'h0, instr};
        r[3] = excep ? excep_cause : commit_data;
        return r;
    endfunction

    // Reference model: per-record queue of expected beats, checked every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_v = (mq.size() > 0);
            chk("valid", trace_valid, exp_v);
            if (exp_v) begin
                chk("beat_data", trace_data, mq[0][bi]);
                chk("beat_last", trace_last, bi == 3);
            end else begin
                chk("idle_data", trace_data, 64'd0);
                chk("idle_last", trace_last, 1'b0);
            end
            chk("armed", armed, m_armed);
            chk("overflow", overflow, m_ovf);
            m_full = (mq.size() == FIFO_DEPTH);
            m_pop  = 1'b0;
            if (trace_valid && trace_ready) obs.push_back(trace_data);
            if (exp_v && trace_ready) begin
                if (bi == 3) begin
                    m_pop = 1'b1;
                    bi    = 0;
                    void'(mq.pop_front());
                end else begin
                    bi++;
                end
            end
            if (commit && !stall_exe && (m_armed || pc == START_PC)) begin
                m_armed = 1'b1;
                if (!m_full || m_pop) begin
                    mq.push_back(make_rec(m_seq, m_drop));
                    m_drop = 8'd0;
                end else begin
                    if (m_drop < 8'd255) m_drop = m_drop + 8'd1;
                    m_ovf = 1'b1;
                end
                m_seq = m_seq + 16'd1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        obs.delete();
        bi = 0; m_armed = 1'b0; m_ovf = 1'b0; m_seq = 16'd0; m_drop = 8'd0;
    endtask

    task automatic apply_reset();
        commit = 1'b0;
        rst = 1'b1;
        model_clear();
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic do_commit(logic [63:0] p, logic [31:0] ins, logic [4:0] d, logic we,
                             logic [63:0] dat, logic exc, logic [63:0] cause);
        pc = p; instr = ins; xreg_dest = d; xreg_we = we; commit_data = dat;
        excep = exc; excep_cause = cause; stall_exe = 1'b0; commit = 1'b1;
        cyc();
        commit = 1'b0;
    endtask

    task automatic wait_beats(int n, int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            cyc();
            k++;
        end
        n_asrt++;
        if (obs.size() < n) begin
            n_fail++;
            $display("FAIL wait_beats: got %0d beats, required %0d", obs.size(), n);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_valid"}, trace_valid, 1'b0);
        chk({tag, "_data"}, trace_data, 64'd0);
        chk({tag, "_last"}, trace_last, 1'b0);
        chk({tag, "_armed"}, armed, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        vec[0] = '{64'h8000_0000, 32'h0070_0293, 5'd5,  1'b1, 64'd7,    1'b0, 64'd0,
                   64'h03C0_0000_2C00_0000, 64'd7};
        vec[1] = '{64'h8000_0004, 32'h0010_0013, 5'd0,  1'b1, 64'd1,    1'b0, 64'd0,
                   64'h03C0_0001_0000_0000, 64'd1};
        vec[2] = '{64'h8000_0008, 32'h0000_4505, 5'd10, 1'b1, 64'd1,    1'b0, 64'd0,
                   64'h03C0_0002_5600_0000, 64'd1};
        vec[3] = '{64'h8000_000A, 32'hFFFF_FFFF, 5'd0,  1'b0, 64'h1234, 1'b1, 64'd2,
                   64'h03E0_0003_0100_0000, 64'd2};
        vec[4] = '{64'h8000_000E, 32'h0000_0393, 5'd7,  1'b0, 64'h55,   1'b0, 64'd0,
                   64'h03C0_0004_3800_0000, 64'h55};

        hart_id = 64'hDEAD_BEEF_0000_0003;
        commit = 1'b0; stall_exe = 1'b0; pc = '0; instr = '0; xreg_dest = '0;
        xreg_we = 1'b0; commit_data = '0; excep = 1'b0; excep_cause = '0;
        trace_ready = 1'b1;
        rst = 1'b1;
        model_clear();
        cyc(); cyc();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Commit away from START_PC must not arm nor produce a record.
        do_commit(64'h1000, 32'h0070_0293, 5'd5, 1'b1, 64'd7, 1'b0, 64'd0);
        cyc(); cyc();
        chk("unarmed_armed", armed, 1'b0);
        chk("unarmed_beats", 64'(obs.size()), 64'd0);

        for (int i = 0; i < 5; i++) begin
            obs.delete();
            do_commit(vec[i].pc, vec[i].instr, vec[i].dest, vec[i].we, vec[i].data,
                      vec[i].exc, vec[i].cause);
            wait_beats(4, 20);
            chk($sformatf("vec%0d_hdr", i), obs[0], vec[i].hdr);
            chk($sformatf("vec%0d_pc", i), obs[1], vec[i].pc);
            chk($sformatf("vec%0d_ins", i), obs[2], {32'h0, vec[i].instr});
            chk($sformatf("vec%0d_b3", i), obs[3], vec[i].b3);
            cyc();
        end
        chk("vec_armed", armed, 1'b1);

        // Overflow: 20 captures into a stalled 16-deep FIFO.
        apply_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            do_commit(START_PC + 64'(4 * i), 32'h13, 5'd1, 1'b1, 64'(i), 1'b0, 64'd0);
        cyc();
        chk("ovf_flag", overflow, 1'b1);
        trace_ready = 1'b1;
        repeat (8) cyc();
        do_commit(64'h8000_1000, 32'h13, 5'd1, 1'b1, 64'd99, 1'b0, 64'd0);
        wait_beats(17 * 4, 300);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ovf_seq%0d", i), 64'(obs[4 * i][47:32]), 64'(i));
        chk("ovf_next_seq", 64'(obs[64][47:32]), 64'd20);
        chk("ovf_next_drop", 64'(obs[64][23:16]), 64'd4);

        // Drop counter saturation.
        apply_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 300; i++)
            do_commit(START_PC, 32'h13, 5'd2, 1'b1, 64'(i), 1'b0, 64'd0);
        trace_ready = 1'b1;
        repeat (8) cyc();
        do_commit(START_PC, 32'h13, 5'd2, 1'b1, 64'd1, 1'b0, 64'd0);
        wait_beats(17 * 4, 400);
        chk("sat_drop", 64'(obs[64][23:16]), 64'd255);
        chk("sat_seq", 64'(obs[64][47:32]), 64'd300);

        // Reset in the middle of a record, then re-arm.
        apply_reset();
        trace_ready = 1'b1;
        do_commit(START_PC, 32'h13, 5'd3, 1'b1, 64'd5, 1'b0, 64'd0);
        wait_beats(2, 20);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrec");
        model_clear();
        cyc();
        rst = 1'b0;
        do_commit(START_PC, 32'h13, 5'd3, 1'b1, 64'd6, 1'b0, 64'd0);
        wait_beats(4, 20);
        chk("rearm_seq", 64'(obs[0][47:32]), 64'd0);
        chk("rearm_type", 64'(obs[0][55:48]), 64'hC0);

        // Random traffic against the reference model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            commit      = ($urandom % 2) == 1;
            stall_exe   = ($urandom % 4) == 0;
            trace_ready = ($urandom % 5) < 3;
            pc          = (($urandom % 10) == 0) ? START_PC : {32'h0, $urandom};
            instr       = $urandom;
            xreg_dest   = 5'($urandom);
            xreg_we     = 1'($urandom);
            commit_data = {$urandom, $urandom};
            excep       = ($urandom % 5) == 0;
            excep_cause = {$urandom, $urandom};
            cyc();
        end
        commit = 1'b0;
        trace_ready = 1'b1;
        for (int k = 0; k < 200 && mq.size() > 0; k++) cyc();
        chk("drain_empty", 64'(mq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
